// File: rtl/bus_pkg.sv
// Shared definitions for the datapath bus source encoder: source indices,
// FSM states and select width.
package bus_pkg;

  localparam int NUM_SRC = 32;
  localparam int SEL_W   = $clog2(NUM_SRC);

  typedef enum logic [4:0] {
    SRC_R0     = 5'd0,
    SRC_R1     = 5'd1,
    SRC_R2     = 5'd2,
    SRC_R3     = 5'd3,
    SRC_R4     = 5'd4,
    SRC_R5     = 5'd5,
    SRC_R6     = 5'd6,
    SRC_R7     = 5'd7,
    SRC_R8     = 5'd8,
    SRC_R9     = 5'd9,
    SRC_R10    = 5'd10,
    SRC_R11    = 5'd11,
    SRC_R12    = 5'd12,
    SRC_R13    = 5'd13,
    SRC_R14    = 5'd14,
    SRC_R15    = 5'd15,
    SRC_HI     = 5'd16,
    SRC_LO     = 5'd17,
    SRC_ZHI    = 5'd18,
    SRC_ZLO    = 5'd19,
    SRC_PC     = 5'd20,
    SRC_MDR    = 5'd21,
    SRC_INPORT = 5'd22,
    SRC_C      = 5'd23
  } src_e;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_e;

endpackage

// File: rtl/prio_encoder_32.sv
// Lowest-index priority encoder over the 32 bus-source request lines,
// with "any request" and "more than one request" indications.
module prio_encoder_32
  import bus_pkg::*;
(
  input  logic [NUM_SRC-1:0] req_i,
  output logic [SEL_W-1:0]   code_o,
  output logic               any_o,
  output logic               multi_o
);

  // Scan from the top down so the lowest set bit is the last one to write the code.
  always_comb begin
    code_o = {SEL_W{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      code_o = req_i[i] ? SEL_W'(i) : code_o;
    end
    any_o   = |req_i;
    multi_o = ((req_i & (req_i - NUM_SRC'(1))) != {NUM_SRC{1'b0}});
  end

endmodule

// File: rtl/bus_source_encoder.sv
// Converts one-hot source requests into a registered 5-bit bus mux select, holds it
// until the destination acknowledges, and tracks collisions and stuck transfers.
module bus_source_encoder
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [NUM_SRC-1:0] src_req,
  input  logic               load_ack,
  input  logic               err_clr,
  output logic [SEL_W-1:0]   sel,
  output logic               bus_valid,
  output logic               busy,
  output logic               collision_err,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   err_count
);

  localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic [7:0]         tmo_q;
  logic               coll_q, coll_d;
  logic               tmo_err_q, tmo_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [SEL_W-1:0]   code_s;
  logic               any_s;
  logic               multi_s;
  logic               latch_s;
  logic               coll_ev_s;
  logic               tmo_ev_s;

  prio_encoder_32 u_prio (
    .req_i   (src_req),
    .code_o  (code_s),
    .any_o   (any_s),
    .multi_o (multi_s)
  );

  // Latch points are IDLE or an ack cycle; an error on the err_clr edge survives the clear.
  always_comb begin
    latch_s   = 1'b0;
    tmo_ev_s  = 1'b0;
    coll_d    = coll_q;
    tmo_err_d = tmo_err_q;
    cnt_d     = cnt_q;
    if (state_q == IDLE) begin
      latch_s = any_s;
    end else begin
      latch_s = any_s && load_ack;
    end
    coll_ev_s = latch_s && multi_s;
    if ((state_q == DRIVE) && !load_ack && (tmo_q == TMO_LAST)) begin
      tmo_ev_s = 1'b1;
    end else begin
      tmo_ev_s = 1'b0;
    end
    if (err_clr) begin
      coll_d    = coll_ev_s;
      tmo_err_d = tmo_ev_s;
      cnt_d     = (coll_ev_s || tmo_ev_s) ? CNT_W'(1) : {CNT_W{1'b0}};
    end else begin
      coll_d    = coll_q | coll_ev_s;
      tmo_err_d = tmo_err_q | tmo_ev_s;
      if ((coll_ev_s || tmo_ev_s) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= IDLE;
      sel_q     <= {SEL_W{1'b0}};
      tmo_q     <= 8'd0;
      coll_q    <= 1'b0;
      tmo_err_q <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      coll_q    <= coll_d;
      tmo_err_q <= tmo_err_d;
      cnt_q     <= cnt_d;
      case (state_q)
        IDLE: begin
          if (latch_s) begin
            sel_q   <= code_s;
            tmo_q   <= 8'd0;
            state_q <= DRIVE;
          end
        end
        DRIVE: begin
          if (load_ack) begin
            if (any_s) begin
              sel_q <= code_s;
              tmo_q <= 8'd0;
            end else begin
              state_q <= IDLE;
            end
          end else if (tmo_ev_s) begin
            tmo_q   <= 8'd0;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sel           = sel_q;
  assign bus_valid     = (state_q == DRIVE);
  assign busy          = (state_q == DRIVE);
  assign collision_err = coll_q;
  assign timeout_err   = tmo_err_q;
  assign err_count     = cnt_q;

endmodule

// File: tb/tb_bus_source_encoder.sv
// Scoreboard bench for bus_source_encoder: each scenario queues its stimulus with
// hand-derived expected outputs, then compares after every clock edge.
module tb_bus_source_encoder;
  import bus_pkg::*;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] src_req = 32'd0;
  logic        load_ack = 1'b0;
  logic        err_clr = 1'b0;
  logic [4:0]  sel;
  logic        bus_valid;
  logic        busy;
  logic        collision_err;
  logic        timeout_err;
  logic [7:0]  err_count;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [4:0] sel;
    logic       valid;
    logic       busy;
    logic       coll;
    logic       tmo;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic [31:0] req;
    logic        ack;
    logic        eclr;
    logic        clr;
    exp_t        e;
  } stim_t;

  exp_t sb[$];

  bus_source_encoder #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clock         (clock),
    .clear         (clear),
    .src_req       (src_req),
    .load_ack      (load_ack),
    .err_clr       (err_clr),
    .sel           (sel),
    .bus_valid     (bus_valid),
    .busy          (busy),
    .collision_err (collision_err),
    .timeout_err   (timeout_err),
    .err_count     (err_count)
  );

  always #5 clock = ~clock;

  function automatic exp_t mk(input logic [4:0] s, input logic v, input logic c,
                              input logic t, input logic [7:0] n);
    exp_t r;
    r = '{sel: s, valid: v, busy: v, coll: c, tmo: t, cnt: n};
    return r;
  endfunction

  function automatic stim_t st(input logic [31:0] req, input logic ack, input logic eclr,
                               input logic clr, input exp_t e);
    stim_t r;
    r.req = req; r.ack = ack; r.eclr = eclr; r.clr = clr; r.e = e;
    return r;
  endfunction

  function automatic logic [31:0] bit_of(input src_e s);
    logic [31:0] one;
    one = 32'd1;
    return one << s;
  endfunction

  task automatic test_reset();
    stim_t q[$];
    exp_t  e, obs;
    q.push_back(st(32'd0, 1'b0, 1'b0, 1'b1, mk(5'd0, 1'b0, 1'b0, 1'b0, 8'd0)));
    q.push_back(st(32'd0, 1'b0, 1'b0, 1'b1, mk(5'd0, 1'b0, 1'b0, 1'b0, 8'd0)));
    q.push_back(st(bit_of(SRC_MDR), 1'b0, 1'b0, 1'b0, mk(5'd21, 1'b1, 1'b0, 1'b0, 8'd0)));
    q.push_back(st(bit_of(SRC_MDR), 1'b0, 1'b0, 1'b1, mk(5'd0, 1'b0, 1'b0, 1'b0, 8'd0)));
    q.push_back(st(bit_of(SRC_MDR), 1'b0, 1'b0, 1'b1, mk(5'd0, 1'b0, 1'b0, 1'b0, 8'd0)));
    q.push_back(st(32'd0, 1'b0, 1'b0, 1'b0, mk(5'd0, 1'b0, 1'b0, 1'b0, 8'd0)));
    for (int i = 0; i < q.size(); i++) begin
      src_req = q[i].req; load_ack = q[i].ack; err_clr = q[i].eclr; clear = q[i].clr;
      sb.push_back(q[i].e);
      @(posedge clock); #1;
      e = sb.pop_front();
      obs = {sel, bus_valid, busy, collision_err, timeout_err, err_count};
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset step %0d: got %p want %p", i, obs, e);
      end
    end
  endtask

  task automatic test_single();
    stim_t q[$];
    exp_t  e, obs;
    q.push_back(st(bit_of(SRC_PC), 1'b0, 1'b0, 1'b0, mk(5'd20, 1'b1, 1'b0, 1'b0, 8'd0)));
    for (int k = 0; k < 3; k++)
      q.push_back(st(32'd0, 1'b0, 1'b0, 1'b0, mk(5'd20, 1'b1, 1'b0, 1'b0, 8'd0)));
    q.push_back(st(32'd0, 1'b1, 1'b0, 1'b0, mk(5'd20, 1'b0, 1'b0, 1'b0, 8'd0)));
    q.push_back(st(32'd0, 1'b0, 1'b0, 1'b0, mk(5'd20, 1'b0, 1'b0, 1'b0, 8'd0)));
    for (int i = 0; i < q.size(); i++) begin
      src_req = q[i].req; load_ack = q[i].ack; err_clr = q[i].eclr; clear = q[i].clr;
      sb.push_back(q[i].e);
      @(posedge clock); #1;
      e = sb.pop_front();
      obs = {sel, bus_valid, busy, collision_err, timeout_err, err_count};
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL single step %0d: got %p want %p", i, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t q[$];
    exp_t  e, obs;
    q.push_back(st(bit_of(SRC_LO), 1'b0, 1'b0, 1'b0, mk(5'd17, 1'b1, 1'b0, 1'b0, 8'd0)));
    q.push_back(st(bit_of(SRC_R5), 1'b1, 1'b0, 1'b0, mk(5'd5, 1'b1, 1'b0, 1'b0, 8'd0)));
    q.push_back(st(bit_of(SRC_R9), 1'b0, 1'b0, 1'b0, mk(5'd5, 1'b1, 1'b0, 1'b0, 8'd0)));
    q.push_back(st(32'd0, 1'b1, 1'b0, 1'b0, mk(5'd5, 1'b0, 1'b0, 1'b0, 8'd0)));
    q.push_back(st(32'd0, 1'b1, 1'b0, 1'b0, mk(5'd5, 1'b0, 1'b0, 1'b0, 8'd0)));
    for (int i = 0; i < q.size(); i++) begin
      src_req = q[i].req; load_ack = q[i].ack; err_clr = q[i].eclr; clear = q[i].clr;
      sb.push_back(q[i].e);
      @(posedge clock); #1;
      e = sb.pop_front();
      obs = {sel, bus_valid, busy, collision_err, timeout_err, err_count};
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL back_to_back step %0d: got %p want %p", i, obs, e);
      end
    end
  endtask

  task automatic test_collision();
    stim_t q[$];
    exp_t  e, obs;
    q.push_back(st(32'h0000_8004, 1'b0, 1'b0, 1'b0, mk(5'd2, 1'b1, 1'b1, 1'b0, 8'd1)));
    q.push_back(st(32'd0, 1'b1, 1'b0, 1'b0, mk(5'd2, 1'b0, 1'b1, 1'b0, 8'd1)));
    q.push_back(st(bit_of(SRC_R3), 1'b0, 1'b0, 1'b0, mk(5'd3, 1'b1, 1'b1, 1'b0, 8'd1)));
    q.push_back(st(32'h0000_FFFF, 1'b0, 1'b0, 1'b0, mk(5'd3, 1'b1, 1'b1, 1'b0, 8'd1)));
    q.push_back(st(32'd0, 1'b1, 1'b0, 1'b0, mk(5'd3, 1'b0, 1'b1, 1'b0, 8'd1)));
    q.push_back(st(32'd0, 1'b0, 1'b1, 1'b0, mk(5'd3, 1'b0, 1'b0, 1'b0, 8'd0)));
    for (int i = 0; i < q.size(); i++) begin
      src_req = q[i].req; load_ack = q[i].ack; err_clr = q[i].eclr; clear = q[i].clr;
      sb.push_back(q[i].e);
      @(posedge clock); #1;
      e = sb.pop_front();
      obs = {sel, bus_valid, busy, collision_err, timeout_err, err_count};
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL collision step %0d: got %p want %p", i, obs, e);
      end
    end
  endtask

  task automatic test_timeout();
    stim_t q[$];
    exp_t  e, obs;
    // First transfer never acked: 15 DRIVE edges, the last one aborts.
    q.push_back(st(bit_of(SRC_R7), 1'b0, 1'b0, 1'b0, mk(5'd7, 1'b1, 1'b0, 1'b0, 8'd0)));
    for (int k = 0; k < 14; k++)
      q.push_back(st(32'd0, 1'b0, 1'b0, 1'b0, mk(5'd7, 1'b1, 1'b0, 1'b0, 8'd0)));
    q.push_back(st(32'd0, 1'b0, 1'b0, 1'b0, mk(5'd7, 1'b0, 1'b0, 1'b1, 8'd1)));
    q.push_back(st(bit_of(SRC_R7), 1'b0, 1'b0, 1'b0, mk(5'd7, 1'b1, 1'b0, 1'b1, 8'd1)));
    for (int k = 0; k < 14; k++)
      q.push_back(st(32'd0, 1'b0, 1'b0, 1'b0, mk(5'd7, 1'b1, 1'b0, 1'b1, 8'd1)));
    q.push_back(st(32'd0, 1'b1, 1'b0, 1'b0, mk(5'd7, 1'b0, 1'b0, 1'b1, 8'd1)));
    q.push_back(st(32'd0, 1'b0, 1'b0, 1'b0, mk(5'd7, 1'b0, 1'b0, 1'b1, 8'd1)));
    for (int i = 0; i < q.size(); i++) begin
      src_req = q[i].req; load_ack = q[i].ack; err_clr = q[i].eclr; clear = q[i].clr;
      sb.push_back(q[i].e);
      @(posedge clock); #1;
      e = sb.pop_front();
      obs = {sel, bus_valid, busy, collision_err, timeout_err, err_count};
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL timeout step %0d: got %p want %p", i, obs, e);
      end
    end
  endtask

  task automatic test_err_clr_priority();
    stim_t q[$];
    exp_t  e, obs;
    q.push_back(st(32'h0000_0003, 1'b0, 1'b1, 1'b0, mk(5'd0, 1'b1, 1'b1, 1'b0, 8'd1)));
    q.push_back(st(32'd0, 1'b1, 1'b0, 1'b0, mk(5'd0, 1'b0, 1'b1, 1'b0, 8'd1)));
    for (int i = 0; i < q.size(); i++) begin
      src_req = q[i].req; load_ack = q[i].ack; err_clr = q[i].eclr; clear = q[i].clr;
      sb.push_back(q[i].e);
      @(posedge clock); #1;
      e = sb.pop_front();
      obs = {sel, bus_valid, busy, collision_err, timeout_err, err_count};
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL err_clr_priority step %0d: got %p want %p", i, obs, e);
      end
    end
  endtask

  task automatic test_saturation();
    stim_t q[$];
    exp_t  e, obs;
    int    n;
    q.push_back(st(32'd0, 1'b0, 1'b1, 1'b0, mk(5'd0, 1'b0, 1'b0, 1'b0, 8'd0)));
    q.push_back(st(32'h0000_0003, 1'b0, 1'b0, 1'b0, mk(5'd0, 1'b1, 1'b1, 1'b0, 8'd1)));
    for (int k = 2; k <= 260; k++) begin
      n = (k > 255) ? 255 : k;
      q.push_back(st(32'h0000_0003, 1'b1, 1'b0, 1'b0, mk(5'd0, 1'b1, 1'b1, 1'b0, 8'(n))));
    end
    q.push_back(st(32'd0, 1'b1, 1'b0, 1'b0, mk(5'd0, 1'b0, 1'b1, 1'b0, 8'd255)));
    q.push_back(st(32'd0, 1'b0, 1'b1, 1'b0, mk(5'd0, 1'b0, 1'b0, 1'b0, 8'd0)));
    for (int i = 0; i < q.size(); i++) begin
      src_req = q[i].req; load_ack = q[i].ack; err_clr = q[i].eclr; clear = q[i].clr;
      sb.push_back(q[i].e);
      @(posedge clock); #1;
      e = sb.pop_front();
      obs = {sel, bus_valid, busy, collision_err, timeout_err, err_count};
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL saturation step %0d: got %p want %p", i, obs, e);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_collision();
    test_timeout();
    test_err_clr_priority();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
